// File: rtl/trng_health_monitor.sv
// Online health monitor for the random byte stream: repetition count, adaptive
// proportion and per-window ones count, gated by a startup/run/fail state machine.
module trng_health_monitor #(
  parameter int RCT_CUTOFF = 4,
  parameter int APT_WINDOW = 64,
  parameter int APT_CUTOFF = 13,
  parameter int STARTUP_N  = 128,
  localparam int W = $clog2(APT_WINDOW * 8 + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clear,
  input  logic         s_valid,
  input  logic [7:0]   s_data,
  output logic         healthy,
  output logic [1:0]   state,
  output logic         rct_fail,
  output logic         apt_fail,
  output logic         win_done,
  output logic [W-1:0] ones_last
);
  localparam int PW = (APT_WINDOW > 2) ? $clog2(APT_WINDOW) : 1;
  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam int AW = $clog2(APT_WINDOW + 1);
  localparam int SW = $clog2(STARTUP_N + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STARTUP = 2'd1,
    S_RUN     = 2'd2,
    S_FAIL    = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic           first_q, first_d;
  logic [7:0]     prev_q, prev_d;
  logic [RW-1:0]  rct_cnt_q, rct_cnt_d;
  logic [PW-1:0]  pos_q, pos_d;
  logic [7:0]     ref_q, ref_d;
  logic [AW-1:0]  apt_cnt_q, apt_cnt_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   ones_last_q, ones_last_d;
  logic [SW-1:0]  su_cnt_q, su_cnt_d;
  logic           rct_fail_q, rct_fail_d;
  logic           apt_fail_q, apt_fail_d;
  logic           win_done_q, win_done_d;
  logic           healthy_q, healthy_d;

  logic [RW-1:0]  rct_next;
  logic [AW-1:0]  apt_next;
  logic [W-1:0]   ones_sum;
  logic           rct_hit, apt_hit;

  function automatic logic [3:0] popcount8(input logic [7:0] b);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, b[i]};
    return n;
  endfunction

  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    prev_d      = prev_q;
    rct_cnt_d   = rct_cnt_q;
    pos_d       = pos_q;
    ref_d       = ref_q;
    apt_cnt_d   = apt_cnt_q;
    acc_d       = acc_q;
    ones_last_d = ones_last_q;
    su_cnt_d    = su_cnt_q;
    rct_fail_d  = rct_fail_q;
    apt_fail_d  = apt_fail_q;
    win_done_d  = 1'b0;
    rct_next    = '0;
    apt_next    = '0;
    ones_sum    = '0;
    rct_hit     = 1'b0;
    apt_hit     = 1'b0;

    // clear wins everywhere; dropping en restarts the monitor unless it is latched in FAIL
    if (clear || (state_q != S_FAIL && !en)) begin
      state_d    = S_IDLE;
      first_d    = 1'b1;
      prev_d     = '0;
      rct_cnt_d  = '0;
      pos_d      = '0;
      ref_d      = '0;
      apt_cnt_d  = '0;
      acc_d      = '0;
      su_cnt_d   = '0;
      rct_fail_d = 1'b0;
      apt_fail_d = 1'b0;
      if (clear) ones_last_d = '0;
    end else if (state_q == S_IDLE) begin
      state_d = S_STARTUP;
    end else if (state_q != S_FAIL && s_valid) begin
      if (first_q || s_data != prev_q) rct_next = RW'(1);
      else if (rct_cnt_q >= RW'(RCT_CUTOFF)) rct_next = rct_cnt_q;
      else rct_next = rct_cnt_q + RW'(1);
      first_d   = 1'b0;
      prev_d    = s_data;
      rct_cnt_d = rct_next;
      rct_hit   = (rct_next >= RW'(RCT_CUTOFF));

      if (pos_q == '0) begin
        ref_d    = s_data;
        apt_next = AW'(1);
      end else begin
        apt_next = apt_cnt_q + AW'(s_data == ref_q);
      end
      apt_cnt_d = apt_next;
      apt_hit   = (apt_next >= AW'(APT_CUTOFF));

      pos_d    = pos_q + PW'(1);
      ones_sum = acc_q + W'(popcount8(s_data));
      if (pos_q == PW'(APT_WINDOW - 1)) begin
        pos_d       = '0;
        ones_last_d = ones_sum;
        acc_d       = '0;
        win_done_d  = 1'b1;
      end else begin
        acc_d = ones_sum;
      end

      if (rct_hit || apt_hit) begin
        state_d    = S_FAIL;
        rct_fail_d = rct_fail_q | rct_hit;
        apt_fail_d = apt_fail_q | apt_hit;
      end else if (state_q == S_STARTUP) begin
        su_cnt_d = su_cnt_q + SW'(1);
        if (su_cnt_q + SW'(1) == SW'(STARTUP_N)) state_d = S_RUN;
      end
    end

    healthy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      first_q     <= 1'b1;
      prev_q      <= '0;
      rct_cnt_q   <= '0;
      pos_q       <= '0;
      ref_q       <= '0;
      apt_cnt_q   <= '0;
      acc_q       <= '0;
      ones_last_q <= '0;
      su_cnt_q    <= '0;
      rct_fail_q  <= 1'b0;
      apt_fail_q  <= 1'b0;
      win_done_q  <= 1'b0;
      healthy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      prev_q      <= prev_d;
      rct_cnt_q   <= rct_cnt_d;
      pos_q       <= pos_d;
      ref_q       <= ref_d;
      apt_cnt_q   <= apt_cnt_d;
      acc_q       <= acc_d;
      ones_last_q <= ones_last_d;
      su_cnt_q    <= su_cnt_d;
      rct_fail_q  <= rct_fail_d;
      apt_fail_q  <= apt_fail_d;
      win_done_q  <= win_done_d;
      healthy_q   <= healthy_d;
    end
  end

  assign state     = state_q;
  assign healthy   = healthy_q;
  assign rct_fail  = rct_fail_q;
  assign apt_fail  = apt_fail_q;
  assign win_done  = win_done_q;
  assign ones_last = ones_last_q;
endmodule

// File: tb/tb_trng_health_monitor.sv
// Directed bench for trng_health_monitor: vector table for the RCT/clear sequence,
// hand-written sequences for startup, APT, en abort and asynchronous reset.
module tb_trng_health_monitor;
  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clear;
  logic       s_valid;
  logic [7:0] s_data;
  logic       healthy;
  logic [1:0] state;
  logic       rct_fail;
  logic       apt_fail;
  logic       win_done;
  logic [9:0] ones_last;

  int n_vec = 0;
  int n_err = 0;

  trng_health_monitor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clear     (clear),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .healthy   (healthy),
    .state     (state),
    .rct_fail  (rct_fail),
    .apt_fail  (apt_fail),
    .win_done  (win_done),
    .ones_last (ones_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       e;
    logic       c;
    logic [1:0] st;
    logic       h;
    logic       rf;
    logic       af;
    logic       wd;
    logic [9:0] ol;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // drive on the falling edge, then look just after the rising edge that captured it
  task automatic step(input logic v, input logic [7:0] d, input logic e, input logic c);
    @(negedge clk);
    s_valid = v;
    s_data  = d;
    en      = e;
    clear   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic h,
                           input logic rf, input logic af, input logic wd,
                           input logic [9:0] ol);
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_healthy"}, 32'(healthy), 32'(h));
    check({tag, "_rct_fail"}, 32'(rct_fail), 32'(rf));
    check({tag, "_apt_fail"}, 32'(apt_fail), 32'(af));
    check({tag, "_win_done"}, 32'(win_done), 32'(wd));
    check({tag, "_ones_last"}, 32'(ones_last), 32'(ol));
  endtask

  initial begin
    vec_t tbl[11];
    tbl[0]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 10'd256};
    tbl[1]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 10'd256};
    tbl[2]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 10'd256};
    tbl[3]  = '{1'b1, 8'h5B, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 10'd256};
    tbl[4]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 10'd256};
    tbl[5]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 10'd256};
    tbl[6]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 10'd256};
    tbl[7]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 10'd256};
    tbl[8]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 10'd256};
    tbl[9]  = '{1'b1, 8'h00, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};

    rst_n   = 1'b0;
    en      = 1'b0;
    clear   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // startup run on 0x00..0x7F
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    check("t1_idle_to_startup", 32'(state), 32'd1);
    for (int i = 0; i < 128; i++) begin
      step(1'b1, 8'(i), 1'b1, 1'b0);
      check_all($sformatf("t1[%0d]", i), (i == 127) ? 2'd2 : 2'd1, (i == 127),
                1'b0, 1'b0, (i == 63 || i == 127),
                (i >= 127) ? 10'd256 : (i >= 63) ? 10'd192 : 10'd0);
    end

    // RCT pass/fail, en ignored in FAIL, clear with a coincident sample
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].e, tbl[i].c);
      check_all($sformatf("tbl[%0d]", i), tbl[i].st, tbl[i].h, tbl[i].rf,
                tbl[i].af, tbl[i].wd, tbl[i].ol);
    end

    // APT: 0x33 interleaved with distinct bytes from a fresh window
    for (int k = 0; k < 25; k++) begin
      step(1'b1, (k % 2 == 0) ? 8'h33 : 8'(8'h80 + k / 2), 1'b1, 1'b0);
      check_all($sformatf("t3[%0d]", k), (k == 24) ? 2'd3 : 2'd1, 1'b0,
                1'b0, (k == 24), 1'b0, 10'd0);
    end
    step(1'b1, 8'h33, 1'b1, 1'b0);
    check("t3_fail_holds", 32'(state), 32'd3);
    check("t3_apt_sticky", 32'(apt_fail), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    check_all("t3_clear", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);

    // en dropped after 100 startup samples: startup and window restart
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t5_startup", 32'(state), 32'd1);
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 8'(i), 1'b1, 1'b0);
      check($sformatf("t5a_state[%0d]", i), 32'(state), 32'd1);
      check($sformatf("t5a_win_done[%0d]", i), 32'(win_done), 32'(i == 63));
    end
    step(1'b1, 8'h99, 1'b0, 1'b0);
    check_all("t5_en_low", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd192);
    step(1'b1, 8'h9A, 1'b1, 1'b0);
    check("t5_restart", 32'(state), 32'd1);
    for (int j = 0; j < 128; j++) begin
      step(1'b1, 8'(j + 128), 1'b1, 1'b0);
      check_all($sformatf("t5b[%0d]", j), (j == 127) ? 2'd2 : 2'd1, (j == 127),
                1'b0, 1'b0, (j == 63 || j == 127),
                (j >= 127) ? 10'd320 : (j >= 63) ? 10'd256 : 10'd192);
    end

    // asynchronous reset mid-window in RUN
    for (int k = 0; k < 10; k++) step(1'b1, 8'(8'h10 + k), 1'b1, 1'b0);
    check("t6_pre_state", 32'(state), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("t6_async", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t6_startup", 32'(state), 32'd1);
    for (int k = 0; k < 64; k++) begin
      step(1'b1, 8'(k), 1'b1, 1'b0);
      check($sformatf("t6_win_done[%0d]", k), 32'(win_done), 32'(k == 63));
      check($sformatf("t6_ones_last[%0d]", k), 32'(ones_last), (k == 63) ? 32'd192 : 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/trng_health_monitor.md
Name: trng_health_monitor

Overview:
Online health checker at the consuming end of the on-chip random byte stream. It follows SP 800-90B practice: a repetition count test (RCT), an adaptive proportion test (APT) and a per-window ones count, all run on each accepted byte. A startup state machine raises `healthy` only after a clean startup run. Any failure latches until cleared, so downstream logic can gate its use of random data.

Parameters:
RCT_CUTOFF, 4, number of consecutive identical samples that triggers an RCT failure (≥2)
APT_WINDOW, 64, samples per APT/ones window (power of 2, ≥2)
APT_CUTOFF, 13, count of samples equal to the window reference that triggers an APT failure (≤APT_WINDOW)
STARTUP_N, 128, clean samples required before `healthy` asserts (≥APT_WINDOW)

Ports:
clk  in  1  clock
rst_n  in  1  reset
en  in  1  monitor enable
clear  in  1  synchronous clear of state, counters and sticky flags
s_valid  in  1  sample strobe; one byte per cycle when high; no backpressure
s_data  in  8  random sample byte
healthy  out  1  high only in RUN
state  out  2  0=IDLE, 1=STARTUP, 2=RUN, 3=FAIL
rct_fail  out  1  sticky RCT failure flag
apt_fail  out  1  sticky APT failure flag
win_done  out  1  one-cycle pulse when an APT window closes
ones_last  out  W  total of '1' bits in the last closed window; W = $clog2(APT_WINDOW*8+1), 10 at defaults

Behaviour:
- Reset and interface: reset rst_n, asynchronous, active-low; clock clk.
- On reset, all outputs are 0, state is IDLE, all counters are 0 and the first-sample flag is set.
- Accepted sample: s_valid & en & (state==STARTUP | state==RUN) & !clear. All other samples are discarded with no counter change.
- clear has priority over every other event. Next cycle: state IDLE, flags 0, counters 0, ones_last 0, first-sample flag set.
- en=0 in any state except FAIL: next cycle state is IDLE and counters reset as for clear, but ones_last is held. In FAIL, en is ignored.
- IDLE with en=1: next state is STARTUP. A sample in that IDLE cycle is discarded.
- STARTUP: the startup counter increments per accepted sample. The STARTUP_N-th accepted sample with no failure sets state RUN on the same edge, so healthy is visible 1 cycle after that sample.
- Any failure, from STARTUP or RUN: state FAIL on the edge capturing the offending sample, and healthy drops the same edge. FAIL holds until clear or reset, and counters freeze.
- RCT:
  - The first accepted sample after reset, clear or IDLE sets prev=s_data and rct_cnt=1.
  - After that: if s_data==prev, rct_cnt increments (saturating at RCT_CUTOFF); otherwise rct_cnt=1 and prev=s_data.
  - rct_cnt reaching RCT_CUTOFF sets rct_fail (registered; visible 1 cycle after the sample).
- APT:
  - Window position 0 loads ref=s_data and apt_cnt=1.
  - Positions 1..APT_WINDOW-1 increment apt_cnt when s_data==ref.
  - apt_cnt reaching APT_CUTOFF sets apt_fail immediately, without waiting for the window to end.
  - After position APT_WINDOW-1 the position wraps to 0, so the next sample is the new reference.
- Ones count: popcount(s_data) accumulates across the window. On the wrap edge, ones_last <= accumulator + popcount(last sample), the accumulator clears and win_done pulses for 1 cycle.
- Simultaneous RCT and APT failure on one sample: both flags set.
- A window closing on the failing sample still updates ones_last and pulses win_done.
- Reset asserted mid-window: counters and outputs clear immediately (asynchronous). The partial window is lost.

Test Plan:
1. Reset, en=1, feed 0x00..0x7F one per cycle:
   - state goes IDLE→STARTUP→RUN; healthy=1 one cycle after byte 0x7F.
   - win_done pulses after 0x3F with ones_last=192, and after 0x7F with ones_last=256.
   - no fail flags.
2. RCT, in RUN:
   - feed 0x5A,0x5A,0x5A,0x5B → no failure.
   - then 0x5A ×4 → rct_fail=1, state=3 and healthy=0, all 1 cycle after the 4th 0x5A; apt_fail stays 0.
3. APT: at a window start, alternate 0x33 with distinct bytes 0x80,0x81,… → apt_fail=1 one cycle after the 13th 0x33 (window position 24); rct_fail=0.
4. In FAIL, assert clear and s_valid=1 in the same cycle → next cycle state=0, both flags 0, ones_last=0; the sample is not counted.
5. In STARTUP after 100 samples, drop en for 1 cycle, then restore → healthy requires a full further 128 samples. No failure occurs, and win_done does not fire for the aborted window.
6. Pulse rst_n low mid-window in RUN → all outputs 0 without a clock edge; after release the first window closes only after 64 new samples.
